// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- serial UART transmitter, one bit period per i_clk cycle.
//
// Frame on o_tx_out: start bit (0), DATA_WIDTH payload bits LSB first,
// optional parity bit (even or odd), one stop bit (1). The line idles high.
//
// Ports
//   i_clk        : bit clock (one UART bit per cycle)
//   i_rst        : synchronous active-high reset, wins over a request
//   i_data       : payload, captured only when a request is accepted
//   i_data_valid : send request, honoured only while idle (never queued)
//   i_par_en     : 1 inserts a parity bit after the payload
//   i_par_type   : 0 even parity, 1 odd parity
//   o_tx_out     : registered serial line
//   o_busy       : registered, high from the start bit through the stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_par_en,
  input  logic                  i_par_type,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit over the payload: XOR-reduction, inverted for odd parity.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

  state_t                state_q,    state_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  par_en_q,   par_en_d;
  logic                  par_type_q, par_type_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic                  tx_q,       tx_d;
  logic                  busy_q,     busy_d;
  logic [CNT_W-1:0]      cnt_nxt;

  assign cnt_nxt  = cnt_q + CNT_ONE;
  assign o_tx_out = tx_q;
  assign o_busy   = busy_q;

  // Next-state logic. The outputs are computed from the state being entered,
  // so the registered line level always matches the registered state.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_type_d = par_type_q;
    cnt_d      = cnt_q;
    tx_d       = 1'b1;
    busy_d     = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_data_valid) begin
          state_d    = S_START;
          data_d     = i_data;
          par_en_d   = i_par_en;
          par_type_d = i_par_type;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end else begin
          tx_d       = 1'b1;
          busy_d     = 1'b0;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = parity_bit(data_q, par_type_q);
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          // Drive the bit the counter will point at after this edge.
          cnt_d = cnt_nxt;
          tx_d  = data_q[cnt_nxt];
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
        tx_d    = 1'b1;
      end
      S_STOP: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, latched frame configuration and registered outputs; reset wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      cnt_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_type_q <= par_type_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- scoreboard bench for uart_tx.
// The stimulus process models the transmitter at frame level (when a request
// is accepted, what bits the frame carries, where a reset cuts it short) and
// pushes the expected frame. A monitor collects every busy period from the
// DUT outputs and compares it with the head of the queue; between frames it
// checks that the line is idle high.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DW = 8;

  typedef struct {
    int          start;
    int          len;
    logic [15:0] bits;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data;
  logic          valid;
  logic          pen;
  logic          ptype;
  logic          tx_out;
  logic          busy;

  frame_t exp_q[$];
  int     edge_n    = 0;
  int     tests_run = 0;
  int     fails     = 0;

  // model state: earliest edge that can accept, and the frame in flight
  int     free_edge = 0;
  bit     have_cur  = 1'b0;
  int     cur_k     = 0;
  int     cur_len   = 0;

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data       (data),
    .i_data_valid (valid),
    .i_par_en     (pen),
    .i_par_type   (ptype),
    .o_tx_out     (tx_out),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Build the expected line sequence of a frame from the protocol rules.
  function automatic frame_t make_frame(input int k, input logic [DW-1:0] d,
                                        input logic pe, input logic pt);
    frame_t f;
    int     ones;
    int     idx;
    f.start = k;
    f.bits  = '0;
    f.bits[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      f.bits[1 + i] = d[i];
      if (d[i]) ones++;
    end
    idx = DW + 1;
    if (pe) begin
      f.bits[idx] = ((ones % 2) == 1) ^ pt;
      idx++;
    end
    f.bits[idx] = 1'b1;
    f.len = idx + 1;
    return f;
  endfunction

  // Frame-level reference: evaluated with the inputs present at edge e.
  task automatic model_edge(input int e);
    frame_t f;
    if (rst) begin
      if (have_cur && (e < cur_k + cur_len) && (exp_q.size() > 0)) begin
        f = exp_q.pop_back();
        f.len = e - cur_k;
        exp_q.push_back(f);
      end
      have_cur  = 1'b0;
      free_edge = e + 1;
    end else if (valid && (e >= free_edge)) begin
      f = make_frame(e, data, pen, ptype);
      exp_q.push_back(f);
      have_cur  = 1'b1;
      cur_k     = e;
      cur_len   = f.len;
      free_edge = e + f.len + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(edge_n);
    edge_n++;
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    data  = d;
    pen   = pe;
    ptype = pt;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (14) tick();
  endtask

  // Monitor: gathers each busy period and scores it against the queue head.
  initial begin
    bit          in_frame;
    int          obs_start;
    int          obs_len;
    logic [15:0] obs_bits;
    logic [15:0] mask;
    frame_t      f;
    in_frame = 1'b0;
    obs_start = 0;
    obs_len = 0;
    obs_bits = '0;
    forever begin
      @(negedge clk);
      if (edge_n > 0) begin
        if (!in_frame) begin
          if (busy === 1'b1) begin
            in_frame    = 1'b1;
            obs_start   = edge_n - 1;
            obs_len     = 1;
            obs_bits    = '0;
            obs_bits[0] = tx_out;
          end else begin
            check((busy === 1'b0) && (tx_out === 1'b1), "idle_line",
                  {30'd0, busy, tx_out}, 32'h1);
          end
        end else if (busy === 1'b1) begin
          if (obs_len < 16) obs_bits[obs_len] = tx_out;
          obs_len++;
        end else begin
          in_frame = 1'b0;
          check(tx_out === 1'b1, "post_frame_idle", {31'd0, tx_out}, 32'h1);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_frame", obs_bits, 32'h0);
          end else begin
            f = exp_q.pop_front();
            check(obs_start == f.start, "frame_start", obs_start, f.start);
            check(obs_len == f.len, "frame_len", obs_len, f.len);
            mask = '0;
            for (int i = 0; i < 16; i++) if (i < f.len) mask[i] = 1'b1;
            check((obs_bits & mask) === (f.bits & mask), "frame_bits",
                  obs_bits & mask, f.bits & mask);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    data  = '0;
    pen   = 1'b0;
    ptype = 1'b0;
    tick();
    tick();
    check(busy === 1'b0, "reset_busy", {31'd0, busy}, 32'h0);
    check(tx_out === 1'b1, "reset_tx", {31'd0, tx_out}, 32'h1);
    rst = 1'b0;

    // no parity, even parity, odd parity boundary cases
    send(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    send(8'h00, 1'b1, 1'b1);

    // inputs changed and valid re-pulsed mid-frame are ignored
    data = 8'h3C; pen = 1'b0; ptype = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    data = 8'hFF; pen = 1'b1; ptype = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (12) tick();

    // continuous valid: back-to-back frames, one idle cycle apart
    data = 8'h55; pen = 1'b0; valid = 1'b1;
    repeat (34) tick();
    valid = 1'b0;
    repeat (12) tick();

    // reset at cycle 5 of a frame, then a fresh frame
    data = 8'hC3; pen = 1'b1; ptype = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check(busy === 1'b0, "abort_busy", {31'd0, busy}, 32'h0);
    check(tx_out === 1'b1, "abort_tx", {31'd0, tx_out}, 32'h1);
    send(8'h5A, 1'b1, 1'b0);

    // reset and valid on the same edge: request dropped
    rst = 1'b1; valid = 1'b1; data = 8'h99;
    tick();
    rst = 1'b0; valid = 1'b0;
    repeat (3) tick();

    // random traffic with occasional resets and input churn mid-frame
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      valid = ($urandom_range(0, 2) == 0);
      data  = DW'($urandom);
      pen   = 1'($urandom_range(0, 1));
      ptype = 1'($urandom_range(0, 1));
      tick();
    end
    rst   = 1'b0;
    valid = 1'b0;
    repeat (20) tick();

    check(exp_q.size() == 0, "frames_pending", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
